// File: rtl/inst_sequencer.sv
// rtl/inst_sequencer.sv - instruction queue with in-order issue, NOP/ACCMOV wait and HALT parking
package inst_sequencer_pkg;
    localparam int INST_NOP    = 0;
    localparam int INST_MATMUL = 1;
    localparam int INST_ACCMOV = 2;
    localparam int INST_LOAD   = 3;
    localparam int INST_STORE  = 4;
    localparam int INST_HALT   = 15;
endpackage

module inst_sequencer
    import inst_sequencer_pkg::*;
#(
    parameter int ADDR_W       = 16,
    parameter int LENGTH_DEPTH = 4,
    parameter int FIFO_DEPTH   = 8,
    parameter int OP_W         = 4
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic                                     in_valid,
    output logic                                     in_ready,
    input  logic [OP_W+3*ADDR_W+LENGTH_DEPTH+5-1:0]  in_inst,
    output logic                                     out_valid,
    input  logic                                     out_ready,
    output logic [OP_W-1:0]                          out_opcode,
    output logic [ADDR_W-1:0]                        out_addr_a,
    output logic [ADDR_W-1:0]                        out_addr_b,
    output logic [ADDR_W-1:0]                        out_addr_c,
    output logic [LENGTH_DEPTH-1:0]                  out_length,
    output logic [4:0]                               out_flags,
    output logic                                     halted,
    input  logic                                     resume,
    output logic [$clog2(FIFO_DEPTH):0]              fifo_count
);
    localparam int INST_W = OP_W + 3 * ADDR_W + LENGTH_DEPTH + 5;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_HALTED} state_t;

    state_t                  state_q, state_d;
    logic [INST_W-1:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]        fifo_count_q, fifo_count_d;
    logic                    in_ready_q, in_ready_d;
    logic                    out_valid_q, out_valid_d;
    logic [INST_W-1:0]       out_inst_q, out_inst_d;
    logic                    halted_q, halted_d;
    logic [LENGTH_DEPTH-1:0] wait_cnt_q, wait_cnt_d;

    logic                    push, pop, handshake, skip, do_load, cand_avail;
    logic [PTR_W-1:0]        cand_idx;
    logic [INST_W-1:0]       cand_inst;
    logic [OP_W-1:0]         cand_op;
    logic [LENGTH_DEPTH-1:0] cand_len;

    // The issued instruction stays in the queue until its handshake, so the
    // candidate for a back-to-back load is the entry just behind the head.
    always_comb begin
        push       = in_valid && in_ready_q;
        handshake  = (state_q == S_ISSUE) && out_ready;
        skip       = handshake;
        cand_idx   = rd_ptr_q + PTR_W'(skip);
        cand_avail = 1'b0;
        cand_inst  = mem_q[cand_idx];
        if (fifo_count_q > CNT_W'(skip)) begin
            cand_avail = 1'b1;
        end else if ((fifo_count_q == CNT_W'(skip)) && push) begin
            cand_avail = 1'b1;
            cand_inst  = in_inst;
        end
        cand_op  = cand_inst[INST_W-1 -: OP_W];
        cand_len = cand_inst[5 +: LENGTH_DEPTH];
    end

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        out_inst_d  = out_inst_q;
        halted_d    = halted_q;
        wait_cnt_d  = wait_cnt_q;
        pop         = 1'b0;
        do_load     = 1'b0;
        case (state_q)
            S_IDLE: do_load = 1'b1;
            S_ISSUE: begin
                if (out_ready) begin
                    pop = 1'b1;
                    if ((out_inst_q[INST_W-1 -: OP_W] == OP_W'(INST_ACCMOV)) &&
                        (out_inst_q[5 +: LENGTH_DEPTH] != '0)) begin
                        out_valid_d = 1'b0;
                        state_d     = S_WAIT;
                        wait_cnt_d  = out_inst_q[5 +: LENGTH_DEPTH];
                    end else begin
                        do_load = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (wait_cnt_q > LENGTH_DEPTH'(1)) begin
                    wait_cnt_d = wait_cnt_q - 1'b1;
                end else begin
                    wait_cnt_d = '0;
                    do_load    = 1'b1;
                end
            end
            S_HALTED: begin
                if (resume) begin
                    halted_d = 1'b0;
                    do_load  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A NOP/HALT right behind a handshake is consumed on the following cycle
        // from IDLE, which keeps the queue to at most one pop per cycle.
        if (do_load) begin
            out_valid_d = 1'b0;
            state_d     = S_IDLE;
            if (cand_avail) begin
                if (cand_op == OP_W'(INST_NOP)) begin
                    if (!handshake) begin
                        pop = 1'b1;
                        if (cand_len != '0) begin
                            state_d    = S_WAIT;
                            wait_cnt_d = cand_len;
                        end
                    end
                end else if (cand_op == OP_W'(INST_HALT)) begin
                    if (!handshake) begin
                        pop      = 1'b1;
                        state_d  = S_HALTED;
                        halted_d = 1'b1;
                    end
                end else begin
                    out_inst_d  = cand_inst;
                    out_valid_d = 1'b1;
                    state_d     = S_ISSUE;
                end
            end
        end

        wr_ptr_d     = wr_ptr_q + PTR_W'(push);
        rd_ptr_d     = rd_ptr_q + PTR_W'(pop);
        fifo_count_d = fifo_count_q + CNT_W'(push) - CNT_W'(pop);
        in_ready_d   = fifo_count_d < CNT_W'(FIFO_DEPTH);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_inst;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fifo_count_q <= '0;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
            out_inst_q   <= '0;
            halted_q     <= 1'b0;
            wait_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            fifo_count_q <= fifo_count_d;
            in_ready_q   <= in_ready_d;
            out_valid_q  <= out_valid_d;
            out_inst_q   <= out_inst_d;
            halted_q     <= halted_d;
            wait_cnt_q   <= wait_cnt_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_opcode = out_inst_q[INST_W-1 -: OP_W];
    assign out_addr_a = out_inst_q[5+LENGTH_DEPTH+2*ADDR_W +: ADDR_W];
    assign out_addr_b = out_inst_q[5+LENGTH_DEPTH+ADDR_W +: ADDR_W];
    assign out_addr_c = out_inst_q[5+LENGTH_DEPTH +: ADDR_W];
    assign out_length = out_inst_q[5 +: LENGTH_DEPTH];
    assign out_flags  = out_inst_q[4:0];
    assign halted     = halted_q;
    assign fifo_count = fifo_count_q;
endmodule

// File: tb/tb_inst_sequencer.sv
// tb/tb_inst_sequencer.sv - directed self-checking bench for inst_sequencer
module tb_inst_sequencer;
    import inst_sequencer_pkg::*;

    localparam int INST_W = 61;

    logic              clk = 1'b0;
    logic              reset, in_valid, in_ready, out_valid, out_ready, halted, resume;
    logic [INST_W-1:0] in_inst;
    logic [3:0]        out_opcode, out_length;
    logic [15:0]       out_addr_a, out_addr_b, out_addr_c;
    logic [4:0]        out_flags;
    logic [3:0]        fifo_count;

    int tests_run    = 0;
    int tests_failed = 0;

    inst_sequencer dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_opcode(out_opcode), .out_addr_a(out_addr_a), .out_addr_b(out_addr_b),
        .out_addr_c(out_addr_c), .out_length(out_length), .out_flags(out_flags),
        .halted(halted), .resume(resume), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    function automatic logic [INST_W-1:0] mk(input int op, input logic [15:0] a, b, c,
                                             input logic [3:0] len, input logic [4:0] fl);
        return {4'(op), a, b, c, len, fl};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1; in_valid = 1'b0; in_inst = '0; out_ready = 1'b0; resume = 1'b0;
        tick; tick;
        reset = 1'b0;
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
        tests_run++; if (fifo_count !== 4'd0) begin tests_failed++; $display("FAIL reset_fifo_count: got %0d want 0", fifo_count); end
        tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
        tests_run++; if (halted !== 1'b0) begin tests_failed++; $display("FAIL reset_halted: got %0b want 0", halted); end
        tests_run++; if ({out_opcode, out_addr_a, out_addr_b, out_addr_c, out_length, out_flags} !== 61'd0) begin
            tests_failed++; $display("FAIL reset_out_fields: got nonzero opcode %0d addr_a %0d", out_opcode, out_addr_a); end
    endtask

    task automatic test_single;
        out_ready = 1'b1;
        in_inst = mk(INST_MATMUL, 16'd4, 16'd4, 16'd9, 4'd2, 5'h15); in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL single_valid_t1: got %0b want 1", out_valid); end
        tests_run++; if (out_addr_a !== 16'd4 || out_addr_b !== 16'd4) begin
            tests_failed++; $display("FAIL single_addr: got a=%0d b=%0d want 4 4", out_addr_a, out_addr_b); end
        tests_run++; if (out_opcode !== 4'(INST_MATMUL) || out_addr_c !== 16'd9 || out_flags !== 5'h15) begin
            tests_failed++; $display("FAIL single_fields: got op=%0d c=%0d fl=%0h want 1 9 15", out_opcode, out_addr_c, out_flags); end
        tick;
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL single_valid_t2: got %0b want 0", out_valid); end
        tests_run++; if (fifo_count !== 4'd0) begin tests_failed++; $display("FAIL single_count: got %0d want 0", fifo_count); end
    endtask

    task automatic test_fill;
        out_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            in_inst = mk(INST_LOAD, 16'(i + 1), 16'd0, 16'd0, 4'd0, 5'd0); in_valid = 1'b1;
            tick;
        end
        in_valid = 1'b0;
        tests_run++; if (fifo_count !== 4'd8) begin tests_failed++; $display("FAIL fill_count: got %0d want 8", fifo_count); end
        tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL fill_in_ready: got %0b want 0", in_ready); end
        tick; tick;
        tests_run++; if (out_valid !== 1'b1 || out_addr_a !== 16'd1) begin
            tests_failed++; $display("FAIL fill_hold: got v=%0b a=%0d want 1 1", out_valid, out_addr_a); end
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tests_run++; if (out_valid !== 1'b1 || out_addr_a !== 16'(i + 1)) begin
                tests_failed++; $display("FAIL fill_drain_%0d: got v=%0b a=%0d want 1 %0d", i, out_valid, out_addr_a, i + 1); end
            tick;
        end
        tests_run++; if (out_valid !== 1'b0 || fifo_count !== 4'd0) begin
            tests_failed++; $display("FAIL fill_empty: got v=%0b count=%0d want 0 0", out_valid, fifo_count); end
    endtask

    task automatic test_accmov;
        out_ready = 1'b1;
        in_inst = mk(INST_ACCMOV, 16'd0, 16'd0, 16'd11, 4'd4, 5'd0); in_valid = 1'b1;
        tick;
        tests_run++; if (out_valid !== 1'b1 || out_opcode !== 4'(INST_ACCMOV) || out_addr_c !== 16'd11) begin
            tests_failed++; $display("FAIL accmov_issue: got v=%0b op=%0d c=%0d want 1 2 11", out_valid, out_opcode, out_addr_c); end
        in_inst = mk(INST_MATMUL, 16'd5, 16'd0, 16'd0, 4'd0, 5'd0);
        tick;
        in_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL accmov_wait_h%0d: got %0b want 0", k, out_valid); end
            tick;
        end
        tests_run++; if (out_valid !== 1'b1 || out_opcode !== 4'(INST_MATMUL) || out_addr_a !== 16'd5) begin
            tests_failed++; $display("FAIL accmov_next_h5: got v=%0b op=%0d a=%0d want 1 1 5", out_valid, out_opcode, out_addr_a); end
        tick;
    endtask

    task automatic test_nop;
        logic        vld [12];
        logic [15:0] adr [12];
        int first, second, issues;
        out_ready = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (i == 0) in_inst = mk(INST_MATMUL, 16'd1, 16'd0, 16'd0, 4'd0, 5'd0);
            else if (i == 1) in_inst = mk(INST_NOP, 16'd0, 16'd0, 16'd0, 4'd3, 5'd0);
            else if (i == 2) in_inst = mk(INST_MATMUL, 16'd2, 16'd0, 16'd0, 4'd0, 5'd0);
            else in_valid = 1'b0;
            tick;
            vld[i] = out_valid; adr[i] = out_addr_a;
        end
        in_valid = 1'b0;
        first = -1; second = -1; issues = 0;
        for (int i = 0; i < 12; i++) begin
            if (vld[i] === 1'b1) begin
                issues++;
                if (first < 0) first = i; else if (second < 0) second = i;
            end
        end
        tests_run++; if (issues != 2) begin tests_failed++; $display("FAIL nop_issue_count: got %0d want 2", issues); end
        tests_run++; if (first != 0 || second != 5) begin
            tests_failed++; $display("FAIL nop_gap: got issues at %0d,%0d want 0,5 (4 idle cycles)", first, second); end
        tests_run++; if (second >= 0 && adr[second] !== 16'd2) begin
            tests_failed++; $display("FAIL nop_second_addr: got %0d want 2", adr[second]); end
    endtask

    task automatic test_halt;
        int bad;
        out_ready = 1'b1;
        in_inst = mk(INST_HALT, 16'd0, 16'd0, 16'd0, 4'd0, 5'd0); in_valid = 1'b1;
        tick;
        in_inst = mk(INST_MATMUL, 16'd7, 16'd0, 16'd0, 4'd0, 5'd0);
        tick;
        in_valid = 1'b0;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (halted !== 1'b1 || out_valid !== 1'b0) bad++;
            tick;
        end
        tests_run++; if (bad != 0) begin tests_failed++; $display("FAIL halt_parked: got %0d bad cycles want 0", bad); end
        tests_run++; if (fifo_count !== 4'd1) begin tests_failed++; $display("FAIL halt_push_accepted: got %0d want 1", fifo_count); end
        resume = 1'b1;
        tick;
        resume = 1'b0;
        tests_run++; if (out_valid !== 1'b1 || out_addr_a !== 16'd7 || halted !== 1'b0) begin
            tests_failed++; $display("FAIL halt_resume: got v=%0b a=%0d h=%0b want 1 7 0", out_valid, out_addr_a, halted); end
        tick;
    endtask

    task automatic test_resume_ignored;
        resume = 1'b1;
        tick;
        resume = 1'b0;
        tests_run++; if (halted !== 1'b0 || out_valid !== 1'b0) begin
            tests_failed++; $display("FAIL resume_ignored: got h=%0b v=%0b want 0 0", halted, out_valid); end
    endtask

    task automatic test_reset_wait;
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_inst = mk(INST_ACCMOV, 16'd0, 16'd0, 16'd3, 4'd8, 5'd0);
        tick;
        for (int i = 1; i <= 3; i++) begin
            in_inst = mk(INST_MATMUL, 16'(i), 16'd0, 16'd0, 4'd0, 5'd0);
            tick;
        end
        in_valid = 1'b0;
        tests_run++; if (fifo_count !== 4'd3 || out_valid !== 1'b0) begin
            tests_failed++; $display("FAIL rstwait_pre: got count=%0d v=%0b want 3 0", fifo_count, out_valid); end
        reset = 1'b1;
        tick;
        reset = 1'b0;
        tests_run++; if (out_valid !== 1'b0 || fifo_count !== 4'd0 || halted !== 1'b0 || in_ready !== 1'b1) begin
            tests_failed++; $display("FAIL rstwait_post: got v=%0b count=%0d h=%0b rdy=%0b want 0 0 0 1", out_valid, fifo_count, halted, in_ready); end
        in_inst = mk(INST_MATMUL, 16'd9, 16'd0, 16'd0, 4'd0, 5'd0); in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        tests_run++; if (out_valid !== 1'b1 || out_addr_a !== 16'd9) begin
            tests_failed++; $display("FAIL rstwait_push: got v=%0b a=%0d want 1 9", out_valid, out_addr_a); end
        tick;
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL rstwait_drain: got %0b want 0", out_valid); end
    endtask

    initial begin
        test_reset;
        test_single;
        test_fill;
        test_accmov;
        test_nop;
        test_halt;
        test_resume_ignored;
        test_reset_wait;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
